// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package instr_fetch_unit_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned OPCODE_W = 4;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [OPCODE_W-1:0] opcode_t;

  typedef enum logic [1:0] {
    ST_START,
    ST_FETCH,
    ST_DRAIN,
    ST_HALT
  } fetch_state_e;

  // Instruction plus the address it was fetched from.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_slot_t;

  localparam word_t   RESET_PC_DEFAULT   = 16'h0000;
  localparam opcode_t HLT_OPCODE_DEFAULT = 4'hF;
  localparam word_t   PC_STEP            = 16'h0002;

  // Sequential PC step; wraps modulo 2^16 without any flag.
  function automatic word_t pc_inc(input word_t pc);
    return WORD_W'(pc + PC_STEP);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Request/acknowledge bus between the fetch stage and instruction memory.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_out_buffer.sv
// Fetch/decode output register: load on a clean fetch, hold under stall,
// clear on consumption or flush.
module fetch_out_buffer
  import instr_fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  flush,
  input  logic  consume,
  input  word_t load_pc,
  input  word_t load_instr,
  output word_t pc,
  output word_t instr,
  output word_t next_pc,
  output logic  valid
);

  fetch_slot_t slot_q;

  assign pc    = slot_q.pc;
  assign instr = slot_q.instr;

  // Output slot register; flush (taken branch) wins over load and consume.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q  <= '0;
      next_pc <= PC_STEP;
      valid   <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      slot_q  <= '{pc: load_pc, instr: load_instr};
      next_pc <= pc_inc(load_pc);
      valid   <= 1'b1;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake, honours
// decode stalls and branch redirects, and stops after a HLT.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter word_t   RESET_PC   = RESET_PC_DEFAULT,
  parameter opcode_t HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      branch_en,
  input  word_t                     branch_pc,
  instr_fetch_unit_if.master        imem,
  output word_t                     curr_pc_f,
  output word_t                     curr_instr_f,
  output word_t                     next_pc_f,
  output logic                      valid_f,
  output logic                      halted
);

  fetch_state_e state;
  logic         req_q;
  word_t        addr_q;
  word_t        fetch_pc;
  logic         squash;
  word_t        target_q;

  opcode_t opcode_c;
  word_t   redirect_c;
  logic    clean_ack_c;
  logic    consume_c;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  assign opcode_c    = imem.imem_data[WORD_W-1 -: OPCODE_W];
  // A branch arriving with the ack is newer than any held target.
  assign redirect_c  = branch_en ? branch_pc : target_q;
  assign clean_ack_c = (state == ST_FETCH) && imem.imem_ack && !squash && !branch_en;
  assign consume_c   = valid_f && !stall;

  // Output register for the fetch/decode boundary.
  fetch_out_buffer u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (clean_ack_c),
    .flush      (branch_en),
    .consume    (consume_c),
    .load_pc    (addr_q),
    .load_instr (imem.imem_data),
    .pc         (curr_pc_f),
    .instr      (curr_instr_f),
    .next_pc    (next_pc_f),
    .valid      (valid_f)
  );

  // Fetch FSM with PC, squash and request registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_START;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      fetch_pc <= RESET_PC;
      squash   <= 1'b0;
      target_q <= RESET_PC;
      halted   <= 1'b0;
    end else begin
      case (state)
        ST_START: begin
          addr_q <= fetch_pc;
          req_q  <= 1'b1;
          state  <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem.imem_ack) begin
            if (squash || branch_en) begin
              // Stale response: drop it and reissue at the redirect target.
              fetch_pc <= redirect_c;
              addr_q   <= redirect_c;
              squash   <= 1'b0;
            end else begin
              fetch_pc <= pc_inc(addr_q);
              req_q    <= 1'b0;
              if (opcode_c == HLT_OPCODE) begin
                halted <= 1'b1;
                state  <= ST_HALT;
              end else begin
                state  <= ST_DRAIN;
              end
            end
          end else if (branch_en) begin
            // Request stays open; remember to discard its data.
            squash   <= 1'b1;
            target_q <= branch_pc;
          end
        end
        ST_DRAIN: begin
          if (branch_en) begin
            fetch_pc <= branch_pc;
            addr_q   <= branch_pc;
            req_q    <= 1'b1;
            state    <= ST_FETCH;
          end else if (consume_c) begin
            addr_q <= fetch_pc;
            req_q  <= 1'b1;
            state  <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (branch_en) begin
            fetch_pc <= branch_pc;
            addr_q   <= branch_pc;
            halted   <= 1'b0;
            req_q    <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_START;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: random-latency memory, random
// stall/branch/reset, checked against program-order and handshake rules.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam word_t       RST_PC = 16'h0000;
  localparam opcode_t     HLT    = 4'hF;
  localparam int unsigned NCYC   = 20000;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  stall;
  logic  branch_en;
  word_t branch_pc;
  word_t curr_pc_f;
  word_t curr_instr_f;
  word_t next_pc_f;
  logic  valid_f;
  logic  halted;

  instr_fetch_unit_if imem_bus ();

  instr_fetch_unit #(
    .RESET_PC   (RST_PC),
    .HLT_OPCODE (HLT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_en    (branch_en),
    .branch_pc    (branch_pc),
    .imem         (imem_bus),
    .curr_pc_f    (curr_pc_f),
    .curr_instr_f (curr_instr_f),
    .next_pc_f    (next_pc_f),
    .valid_f      (valid_f),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic  rst_n;
    logic  stall;
    logic  branch_en;
    word_t branch_pc;
    logic  req;
    logic  ack;
    word_t addr;
    word_t data;
    logic  valid;
    logic  halted;
    word_t pc;
    word_t instr;
    word_t npc;
  } cyc_t;

  word_t mem [256];
  int    total = 0;
  int    bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    cyc_t  prev;
    cyc_t  cur;
    logic  prev2_rst;
    word_t exp_pc;
    logic  redir;
    logic  clean;
    logic  busy;
    int    cnt;
    int    n_present;
    logic  rst_next;
    word_t w;

    for (int i = 0; i < 256; i++) begin
      w = word_t'($urandom);
      if ($urandom_range(0, 9) == 0) w[15:12] = HLT;
      else if (w[15:12] == HLT) w[15:12] = 4'h1;
      mem[i] = w;
    end
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    mem[3] = 16'hF000;

    rst_n              = 1'b0;
    stall              = 1'b0;
    branch_en          = 1'b0;
    branch_pc          = '0;
    imem_bus.imem_ack  = 1'b0;
    imem_bus.imem_data = '0;
    prev               = '0;
    prev2_rst          = 1'b0;
    exp_pc             = RST_PC;
    redir              = 1'b0;
    busy               = 1'b0;
    cnt                = 0;
    n_present          = 0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cur           = prev;
      cur.req       = imem_bus.imem_req;
      cur.addr      = imem_bus.imem_addr;
      cur.valid     = valid_f;
      cur.halted    = halted;
      cur.pc        = curr_pc_f;
      cur.instr     = curr_instr_f;
      cur.npc       = next_pc_f;

      // Advance the program-order model with last cycle's events.
      clean = 1'b0;
      if (!prev.rst_n) begin
        exp_pc = RST_PC;
        redir  = 1'b0;
      end else begin
        clean = prev.ack && !redir && !prev.branch_en;
        if (prev.branch_en)  exp_pc = prev.branch_pc;
        else if (clean)      exp_pc = 16'(prev.addr + 16'd2);
        if (prev.ack)                         redir = 1'b0;
        else if (prev.branch_en && prev.req)  redir = 1'b1;
      end

      if (!prev.rst_n) begin
        check_eq("rst_req",    cur.req,    1'b0);
        check_eq("rst_addr",   cur.addr,   RST_PC);
        check_eq("rst_valid",  cur.valid,  1'b0);
        check_eq("rst_pc",     cur.pc,     16'h0000);
        check_eq("rst_instr",  cur.instr,  16'h0000);
        check_eq("rst_npc",    cur.npc,    16'h0002);
        check_eq("rst_halted", cur.halted, 1'b0);
      end else begin
        if (!prev2_rst) begin
          check_eq("first_req",  cur.req,  1'b1);
          check_eq("first_addr", cur.addr, RST_PC);
        end
        if (prev.branch_en) begin
          check_eq("br_valid",  cur.valid,  1'b0);
          check_eq("br_halted", cur.halted, 1'b0);
          if (!prev.req) begin
            check_eq("br_req",  cur.req,  1'b1);
            check_eq("br_addr", cur.addr, prev.branch_pc);
          end
        end
        if (prev.req && !prev.ack) begin
          check_eq("open_req",  cur.req,  1'b1);
          check_eq("open_addr", cur.addr, prev.addr);
        end
        if (prev.ack) begin
          if (clean) begin
            check_eq("ack_valid",  cur.valid,  1'b1);
            check_eq("ack_pc",     cur.pc,     prev.addr);
            check_eq("ack_instr",  cur.instr,  prev.data);
            check_eq("ack_npc",    cur.npc,    16'(prev.addr + 16'd2));
            check_eq("ack_halted", cur.halted, prev.data[15:12] == HLT);
            check_eq("ack_req",    cur.req,    1'b0);
          end else begin
            check_eq("drop_valid", cur.valid, 1'b0);
            check_eq("drop_req",   cur.req,   1'b1);
          end
        end
        if (prev.valid && !prev.branch_en) begin
          if (prev.stall) begin
            check_eq("hold_valid",  cur.valid,  1'b1);
            check_eq("hold_pc",     cur.pc,     prev.pc);
            check_eq("hold_instr",  cur.instr,  prev.instr);
            check_eq("hold_npc",    cur.npc,    prev.npc);
            check_eq("hold_req",    cur.req,    1'b0);
            check_eq("hold_halted", cur.halted, prev.halted);
          end else begin
            check_eq("use_valid",  cur.valid,  1'b0);
            check_eq("use_halted", cur.halted, prev.halted);
            check_eq("use_req",    cur.req,    !prev.halted);
          end
        end
        if (prev.halted && !prev.branch_en) begin
          check_eq("halt_stay", cur.halted, 1'b1);
          check_eq("halt_req",  cur.req,    1'b0);
        end
        if (cur.req && (!prev.req || prev.ack))
          check_eq("req_target", cur.addr, exp_pc);
        if (cur.valid)
          check_eq("valid_noreq", cur.req, 1'b0);
      end

      if (clean) n_present++;
      prev2_rst = prev.rst_n;

      // Drive this cycle's inputs.
      rst_next = !(c > 2 && $urandom_range(0, 199) == 0);
      rst_n    = rst_next;
      stall    = ($urandom_range(0, 2) == 0);
      branch_en = rst_next && prev.rst_n && ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 15))
        0:       branch_pc = 16'hFFFE;
        1:       branch_pc = word_t'($urandom_range(0, 511)) | 16'h0001;
        default: branch_pc = word_t'($urandom_range(0, 255)) << 1;
      endcase

      // Memory with random latency 0..4; reset together with the DUT.
      imem_bus.imem_ack  = 1'b0;
      imem_bus.imem_data = word_t'($urandom);
      if (!rst_next) begin
        busy = 1'b0;
      end else if (cur.req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = $urandom_range(0, 4);
        end
        if (cnt == 0) begin
          imem_bus.imem_ack  = 1'b1;
          imem_bus.imem_data = mem[cur.addr[8:1]];
          busy               = 1'b0;
        end else begin
          cnt--;
        end
      end else begin
        busy = 1'b0;
      end

      cur.rst_n     = rst_n;
      cur.stall     = stall;
      cur.branch_en = branch_en;
      cur.branch_pc = branch_pc;
      cur.ack       = imem_bus.imem_ack;
      cur.data      = imem_bus.imem_data;
      prev          = cur;
    end

    check_eq("progress", n_present > 100, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage of the pipelined 16-bit CPU. It owns the architectural PC and fetches instructions from a multi-cycle instruction memory over a req/ack handshake. Each fetched instruction is presented with its PC and PC+2 to the fetch/decode pipeline register. The block honours decode-stage stalls, redirects on taken branches, and stops fetching after a HLT.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value after reset
- HLT_OPCODE, 4'hF, value of instr[15:12] that marks a halt instruction

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  decode cannot accept; hold presented instruction
- branch_en  in  1  taken branch resolved in decode; redirect fetch
- branch_pc  in  16  redirect target, sampled when branch_en=1
- imem_req  out  1  instruction memory request
- imem_addr  out  16  request address, stable while imem_req=1
- imem_ack  in  1  one-cycle response strobe; may assert in the first req cycle
- imem_data  in  16  instruction, valid only with imem_ack
- curr_pc_f  out  16  PC of presented instruction
- curr_instr_f  out  16  presented instruction
- next_pc_f  out  16  curr_pc_f + 2 (for PCS)
- valid_f  out  1  presented instruction is live
- halted  out  1  fetch has stopped on HLT

## Operation
- Internal state: fetch_pc (next address to fetch), addr_q (drives imem_addr), squash flag, branch target hold, output register {pc, instr, valid}, FSM.
- FSM states:
  - START: one cycle after reset; loads addr_q<=fetch_pc; goes to FETCH.
  - FETCH: imem_req=1, imem_addr=addr_q.
  - DRAIN: imem_req=0; waits for the presented instruction to be consumed.
  - HALT: imem_req=0.
- FETCH:
  - On ack with squash=0 and branch_en=0:
    - Load output register {addr_q, imem_data}; set valid_f=1.
    - fetch_pc<=addr_q+2.
    - Go to HALT if imem_data[15:12]==HLT_OPCODE, else to DRAIN.
  - On ack with squash=1 or branch_en=1:
    - Discard data; clear squash.
    - fetch_pc and addr_q <= pending target (branch_pc if branch_en this cycle).
    - Stay in FETCH.
  - On branch_en with no ack: set squash; hold branch_pc as the target.
    - imem_req and imem_addr stay unchanged until the ack. An open request is never dropped.
- DRAIN:
  - Consumed (valid_f=1, stall=0): valid_f<=0; addr_q<=fetch_pc; go to FETCH.
  - branch_en: valid_f<=0; fetch_pc and addr_q <= branch_pc; go to FETCH.
- HALT:
  - valid_f is held until consumed, then cleared.
  - halted=1 for as long as the FSM stays in HALT.
  - branch_en (an older branch squashes the HLT): valid_f<=0; addr_q<=branch_pc; halted<=0; go to FETCH.
- Priority: reset > branch_en > stall.
  - branch_en always clears valid_f, even when stall=1.
- Arithmetic: PC increments are 16-bit modulo; 16'hFFFE+2 = 16'h0000, with no flag.
- A branch_pc that is not halfword-aligned is used as given; alignment is not checked.

## Timing
- Reset values (after any edge with rst_n=0):
  - state=START, imem_req=0, imem_addr=RESET_PC.
  - valid_f=0, curr_pc_f=0, curr_instr_f=0, next_pc_f=2, halted=0, squash=0.
- First imem_req=1 occurs 2 cycles after rst_n rises (the START cycle, then FETCH).
- Reset during an open request abandons it. The instruction memory is reset in the same cycle.
- Ack in cycle t: valid_f=1 and the outputs are updated at t+1.
- Consumption at t+1 (stall=0): imem_req=1 at t+2.
- Peak throughput is one instruction per (memory latency + 2) cycles. With zero-wait memory that is one instruction per 2 cycles.
- Outputs are registered; none depend combinationally on stall or branch_en.
- After branch_en in cycle t with no fetch open:
  - valid_f=0 at t+1.
  - imem_req=1 with imem_addr=branch_pc at t+1.
- branch_en coincident with ack: data is dropped; the new request starts the next cycle.

## Structure
- Shared package: FSM state enum (START, FETCH, DRAIN, HALT), HLT_OPCODE default, RESET_PC default, 16-bit word type.
- One natural sub-module: fetch_out_buffer, holding the output register with load/hold/flush control.
- FSM, PC, and squash logic stay at the top level.

## Test plan
- Reset release, zero-wait memory returning 16'h1234 at 0x0000 and 16'h5678 at 0x0002:
  - imem_addr sequence 0x0000, 0x0002.
  - valid_f pulses with curr_pc_f=0x0000/next_pc_f=0x0002, then 0x0002/0x0004.
- stall held for 5 cycles while valid_f=1:
  - Outputs are frozen and imem_req=0 throughout.
  - On stall release, the next request goes to pc+2.
- branch_en with branch_pc=0x0040 in cycle 2 of a 4-cycle-latency fetch of 0x0004:
  - imem_addr stays 0x0004 until ack.
  - The data is dropped and valid_f stays 0.
  - The next request goes to 0x0040.
- HLT 16'hF000 fetched at 0x0006:
  - Presented with valid_f=1; halted=1.
  - No further imem_req after consumption.
- branch_en to 0x0010 while HALT and valid_f=1:
  - valid_f=0 and halted=0 next cycle.
  - imem_req=1 at 0x0010.
- rst_n low for one cycle during an open request at 0x0020:
  - Next edge shows reset values.
  - The fetch restarts at RESET_PC.
